// File: rtl/present80_round_ctrl.sv
// present80_round_ctrl
// Iterative PRESENT-80 encryption engine. One cipher round (addRoundKey,
// sLayer, pLayer) is applied per clock to a 64-bit state register while the
// 80-bit key schedule advances in lockstep. After ROUNDS rounds a final
// key-whitening step produces the ciphertext.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   start       encryption request, sampled only while busy is low
//   plaintext   64-bit block, captured on an accepted start
//   key         80-bit cipher key, captured on an accepted start
//   busy        high from the cycle after an accepted start until done
//   done        one-cycle pulse when ciphertext is updated
//   ciphertext  result register, holds until the next done
//
// Timing: a start accepted on edge T gives done/ciphertext after edge
// T+ROUNDS+1. The FSM is back in IDLE during the done cycle, so a new start
// can be accepted there, giving ROUNDS+2 cycles between blocks.

module present80_round_ctrl #(
  parameter int ROUNDS = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] plaintext,
  input  logic [79:0] key,
  output logic        busy,
  output logic        done,
  output logic [63:0] ciphertext
);

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL
  } fsm_t;

  // Round counter value of the last full round.
  localparam logic [4:0] LAST_RC = 5'(ROUNDS);

  fsm_t        fsm_state;
  logic [63:0] state_reg;
  logic [79:0] key_reg;
  logic [4:0]  rc;

  // PRESENT 4-bit S-box, shared by the sLayer and the key schedule.
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // Sixteen parallel S-boxes across the state.
  function automatic logic [63:0] s_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 16; i++) begin
      y[4*i +: 4] = sbox(x[4*i +: 4]);
    end
    return y;
  endfunction

  // Bit permutation: LSB-indexed bit j moves to 16*j mod 63, bit 63 fixed.
  // Pure wiring once the loop is unrolled.
  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int j = 0; j < 63; j++) begin
      y[(16 * j) % 63] = x[j];
    end
    y[63] = x[63];
    return y;
  endfunction

  // Key schedule step: rotate left by 61, S-box the top nibble, then fold
  // the round counter into bits [19:15].
  function automatic logic [79:0] key_update(input logic [79:0] k,
                                             input logic [4:0]  round_cnt);
    logic [79:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = sbox(r[79:76]);
    r[19:15]   = r[19:15] ^ round_cnt;
    return r;
  endfunction

  // Control FSM and datapath registers. The round key is always the top 64
  // bits of key_reg, so the final whitening key is whatever the schedule
  // holds after the last round update. done is cleared by default so it is
  // only ever a single-cycle pulse from FINAL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_state  <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      ciphertext <= '0;
      state_reg  <= '0;
      key_reg    <= '0;
      rc         <= '0;
    end else begin
      done <= 1'b0;
      case (fsm_state)
        IDLE: begin
          if (start) begin
            state_reg <= plaintext;
            key_reg   <= key;
            rc        <= 5'd1;
            busy      <= 1'b1;
            fsm_state <= ROUND;
          end
        end
        ROUND: begin
          state_reg <= p_layer(s_layer(state_reg ^ key_reg[79:16]));
          key_reg   <= key_update(key_reg, rc);
          rc        <= rc + 5'd1;
          if (rc == LAST_RC) begin
            fsm_state <= FINAL;
          end
        end
        FINAL: begin
          ciphertext <= state_reg ^ key_reg[79:16];
          done       <= 1'b1;
          busy       <= 1'b0;
          fsm_state  <= IDLE;
        end
        default: begin
          fsm_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/present80_round_ctrl.md
Name: present80_round_ctrl

Overview:
Iterative PRESENT-80 block-cipher engine controller. It sequences one cipher round per clock over the 64-bit state register: addRoundKey, sLayer, then pLayer. It runs the 80-bit key schedule in lockstep and applies the final key whitening. A start/done handshake sits between the bus-side loader and the cipher datapath.

Parameters:
ROUNDS, 31, number of full rounds executed. Legal range 1..31; 31 gives standard PRESENT-80.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only while busy=0
plaintext  input  64  block to encrypt; bit 63 = MSB; captured on accepted start
key  input  80  cipher key; bit 79 = MSB; captured on accepted start
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse when ciphertext is updated
ciphertext  output  64  result register; holds until the next done

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, ciphertext=0; state, key and round registers=0.
- FSM: IDLE -> ROUND -> FINAL -> IDLE.
- IDLE, start=1 on edge T: state_reg<=plaintext, key_reg<=key, rc<=1, go to ROUND. busy=1 from T.
- ROUND, each edge:
  - state_reg <= P(S(state_reg ^ key_reg[79:16])).
  - key_reg <= KS(key_reg, rc); rc <= rc+1.
  - After the edge that processes rc=ROUNDS, go to FINAL.
- FINAL, one edge: ciphertext <= state_reg ^ key_reg[79:16]; done<=1 for exactly one cycle; busy<=0; go to IDLE.
- Latency: start sampled on edge T; ciphertext and done visible after edge T+ROUNDS+1 (T+32 for default).
- Throughput: a start is accepted in the cycle done is high, because the FSM is already in IDLE. Back-to-back blocks therefore have 33-cycle spacing at default.
- start while busy=1 is ignored; no queueing. plaintext and key are don't-care outside the accepting edge.
- S (sLayer): each of the 16 nibbles is mapped through the table 0..F -> C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
- P (pLayer): 64-bit bit permutation, MSB-first indexing (index 0 = bit 63). Output index k = input index 4*(k mod 16) + (k div 16). Equivalently, LSB-indexed bit j moves to 16*j mod 63, and bit 63 stays fixed.
- KS (key schedule): rotate key_reg left by 61. Then bits [79:76] pass through S. Then bits [19:15] are XORed with rc (5 bits).
- rc is 5 bits wide. It reaches ROUNDS (31 max) and is not used after the FINAL state, so no wrap handling is required.
- Reset mid-operation: the FSM aborts to IDLE immediately and ciphertext clears to 0. No done pulse is generated.
- ciphertext changes only on the FINAL edge and on reset.

Test Plan:
- Reset: rst=1 mid-ROUND (round 10) -> busy=0, done=0, ciphertext=0 immediately; the next start runs a full 32-cycle encryption.
- Vector 1: plaintext=0, key=0, start at edge T -> done high after edge T+32, ciphertext=5579C1387B228445.
- Vector 2: plaintext=0, key=FFFFFFFFFFFFFFFFFFFF -> ciphertext=E72C46C0F5945049.
- Vectors 3 and 4:
  - plaintext=FFFFFFFFFFFFFFFF, key=0 -> ciphertext=A112FFC72F68417B.
  - both all-ones -> ciphertext=3333DCD3213210D2.
- Handshake:
  - start pulsed on every cycle while busy with changing plaintext -> ignored; result equals the first accepted block.
  - start asserted in the done cycle -> accepted; second done arrives exactly 33 cycles after the first.
- Permutation check: ROUNDS=1, key=0, plaintext=0000000000000001.
  - S maps nibble 0 to C and nibble 1 to 5, so the pre-P state is CCCCCCCCCCCCCCC5.
  - The bench computes the expected value from the P formula above and matches ciphertext to it (round-1 key XOR included). busy must be high for exactly 2 cycles.
